// File: rtl/time_set_sequencer.sv
// Time-setting field editor: snapshots the running time, steps hour/min/sec with
// select/increment keys (auto-repeat, blink mask) and commits with load_time. Optional TIME_SET_DEC_KEY_EN adds dec_key.
module time_set_sequencer #(
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter int BLINK_TICKS  = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       set_time_en,
    input  logic       sel_key,
    input  logic       inc_key,
`ifdef TIME_SET_DEC_KEY_EN
    input  logic       dec_key,
`endif
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic [5:0] edit_sec,
    output logic       load_time,
    output logic [2:0] blink_mask
);

    localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);
    localparam int BLK_W    = $clog2(BLINK_TICKS + 1);

    typedef enum logic [1:0] {IDLE, HOUR, MIN, SEC} state_t;

    state_t             state_q, state_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic               load_q, load_d;
    logic [2:0]         mask_q, mask_d;
    logic               phase_q, phase_d;
    logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               hold_act_q, hold_act_d;
    logic               en_dly_q, sel_dly_q, inc_dly_q;

    logic en_rise, en_fall, sel_edge, inc_edge;
    logic dec_lvl, dec_edge, dir_q;
    logic key_held, both_held;
    logic step, step_dn, restart;

    // Wrapping +/-1 of one field; anything above maxv counts as out of range.
    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] maxv,
                                              input logic dn);
        if (dn) return (v == 6'd0 || v > maxv) ? maxv : v - 6'd1;
        return (v >= maxv) ? 6'd0 : v + 6'd1;
    endfunction

    // Edge-detect copies are left unreset so a level held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        en_dly_q  <= set_time_en;
        sel_dly_q <= sel_key;
        inc_dly_q <= inc_key;
    end

    assign en_rise  = set_time_en & ~en_dly_q;
    assign en_fall  = ~set_time_en & en_dly_q;
    assign sel_edge = sel_key & ~sel_dly_q;
    assign inc_edge = inc_key & ~inc_dly_q;

`ifdef TIME_SET_DEC_KEY_EN
    logic dec_dly_q;
    logic dir_d;

    always_ff @(posedge clk) dec_dly_q <= dec_key;

    assign dec_lvl  = dec_key;
    assign dec_edge = dec_key & ~dec_dly_q;
    assign dir_d    = (inc_edge ^ dec_edge) ? dec_edge : dir_q;

    always_ff @(posedge clk) begin
        if (!rst_n) dir_q <= 1'b0;
        else        dir_q <= dir_d;
    end
`else
    assign dec_lvl  = 1'b0;
    assign dec_edge = 1'b0;
    assign dir_q    = 1'b0;
`endif

    assign key_held  = dir_q ? dec_lvl : inc_key;
    assign both_held = inc_key & dec_lvl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            load_q      <= 1'b0;
            mask_q      <= '0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
            hold_cnt_q  <= '0;
            hold_act_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            load_q      <= load_d;
            mask_q      <= mask_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_act_q  <= hold_act_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        load_d      = 1'b0;
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        hold_act_d  = hold_act_q;
        step        = 1'b0;
        step_dn     = 1'b0;
        restart     = 1'b0;
        mask_d      = 3'b000;

        if (tick) begin
            if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Hold counter counts down from HOLD_TICKS, then REPEAT_TICKS, firing at 1.
        if (!key_held) begin
            hold_act_d = 1'b0;
            hold_cnt_d = '0;
        end else if (hold_act_q && tick && !both_held) begin
            if (hold_cnt_q <= CNT_W'(1)) begin
                step       = 1'b1;
                step_dn    = dir_q;
                hold_cnt_d = CNT_W'(REPEAT_TICKS);
            end else begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end

        if (state_q == IDLE) begin
            hold_act_d  = 1'b0;
            hold_cnt_d  = '0;
            phase_d     = 1'b0;
            blink_cnt_d = '0;
            if (en_rise) begin
                hour_d  = cur_hour;
                min_d   = cur_min;
                sec_d   = cur_sec;
                state_d = HOUR;
            end
        end else if (en_fall) begin
            // Exit outranks any key edge or repeat step in the same cycle.
            load_d      = 1'b1;
            state_d     = IDLE;
            hold_act_d  = 1'b0;
            hold_cnt_d  = '0;
            phase_d     = 1'b0;
            blink_cnt_d = '0;
        end else begin
            if (sel_edge) begin
                step       = 1'b0;
                restart    = 1'b1;
                hold_act_d = 1'b0;
                hold_cnt_d = '0;
                case (state_q)
                    HOUR:    state_d = MIN;
                    MIN:     state_d = SEC;
                    default: state_d = HOUR;
                endcase
            end else if (inc_edge ^ dec_edge) begin
                step       = 1'b1;
                step_dn    = dec_edge;
                hold_act_d = 1'b1;
                hold_cnt_d = CNT_W'(HOLD_TICKS);
            end else if (inc_edge & dec_edge) begin
                step       = 1'b0;
                hold_act_d = 1'b0;
                hold_cnt_d = '0;
            end

            if (step) begin
                restart = 1'b1;
                case (state_q)
                    HOUR:    hour_d = 5'(step_field({1'b0, hour_q}, 6'd23, step_dn));
                    MIN:     min_d  = step_field(min_q, 6'd59, step_dn);
                    default: sec_d  = step_field(sec_q, 6'd59, step_dn);
                endcase
            end
        end

        if (restart) begin
            phase_d     = 1'b0;
            blink_cnt_d = '0;
        end

        if (phase_d) begin
            case (state_d)
                HOUR:    mask_d = 3'b100;
                MIN:     mask_d = 3'b010;
                SEC:     mask_d = 3'b001;
                default: mask_d = 3'b000;
            endcase
        end
    end

    assign edit_hour  = hour_q;
    assign edit_min   = min_q;
    assign edit_sec   = sec_q;
    assign load_time  = load_q;
    assign blink_mask = mask_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed self-checking bench for time_set_sequencer with default timing parameters.
module tb_time_set_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, tick, set_time_en, sel_key, inc_key, dec_key;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] edit_hour;
    logic [5:0] edit_min, edit_sec;
    logic       load_time;
    logic [2:0] blink_mask;

    int checks = 0;
    int failures = 0;

    time_set_sequencer #(
        .HOLD_TICKS(50), .REPEAT_TICKS(10), .BLINK_TICKS(25)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .set_time_en(set_time_en),
        .sel_key(sel_key), .inc_key(inc_key),
`ifdef TIME_SET_DEC_KEY_EN
        .dec_key(dec_key),
`endif
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .edit_hour(edit_hour), .edit_min(edit_min), .edit_sec(edit_sec),
        .load_time(load_time), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic inc_pulse(input int n);
        repeat (n) begin
            inc_key = 1'b1;
            cyc(1);
            inc_key = 1'b0;
            cyc(1);
        end
    endtask

    task automatic sel_pulse(input int n);
        repeat (n) begin
            sel_key = 1'b1;
            cyc(1);
            sel_key = 1'b0;
            cyc(1);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_hour"}, 32'(edit_hour), 32'(h));
        chk({tag, "_min"},  32'(edit_min),  32'(m));
        chk({tag, "_sec"},  32'(edit_sec),  32'(s));
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; set_time_en = 1'b0;
        sel_key = 1'b0; inc_key = 1'b0; dec_key = 1'b0;
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        cyc(3);
        chk_time("reset", 0, 0, 0);
        chk("reset_load", 32'(load_time), 0);
        chk("reset_mask", 32'(blink_mask), 0);
        rst_n = 1'b1;
        cyc(1);

        // Entry snapshot and blink phase
        set_time_en = 1'b1;
        cyc(1);
        chk_time("entry", 12, 34, 56);
        chk("entry_mask", 32'(blink_mask), 0);
        ticks(24);
        chk("blink_24", 32'(blink_mask), 0);
        ticks(1);
        chk("blink_25", 32'(blink_mask), 3'b100);
        ticks(25);
        chk("blink_50", 32'(blink_mask), 0);

        // Hour wrap 23 -> 0, increment restarts blink
        inc_pulse(11);
        chk("hour_23", 32'(edit_hour), 23);
        ticks(25);
        chk("hour_blink", 32'(blink_mask), 3'b100);
        inc_pulse(1);
        chk_time("hour_wrap", 0, 34, 56);
        chk("inc_restart_mask", 32'(blink_mask), 0);

        // Select twice to SEC, second wrap 59 -> 0
        sel_pulse(2);
        ticks(25);
        chk("sec_blink", 32'(blink_mask), 3'b001);
        inc_pulse(3);
        chk("sec_59", 32'(edit_sec), 59);
        inc_pulse(1);
        chk_time("sec_wrap", 0, 34, 0);

        // SEC -> HOUR wrap of select, then MIN
        sel_pulse(1);
        ticks(25);
        chk("sel_wrap_blink", 32'(blink_mask), 3'b100);
        sel_pulse(1);
        inc_pulse(26);
        chk_time("min_zero", 0, 0, 0);

        // Auto-repeat: edge, tick 50, then every 10 ticks to 100
        inc_key = 1'b1;
        cyc(1);
        chk("hold_edge", 32'(edit_min), 1);
        ticks(49);
        chk("hold_49", 32'(edit_min), 1);
        ticks(1);
        chk("hold_50", 32'(edit_min), 2);
        ticks(50);
        chk("hold_100", 32'(edit_min), 7);
        inc_key = 1'b0;
        cyc(1);
        ticks(20);
        chk("released", 32'(edit_min), 7);

        // Select while held clears repeat
        inc_key = 1'b1;
        cyc(1);
        chk("held_edge", 32'(edit_min), 8);
        sel_key = 1'b1;
        cyc(1);
        sel_key = 1'b0;
        ticks(60);
        chk_time("sel_while_held", 0, 8, 0);
        inc_key = 1'b0;
        cyc(1);

        // SEC -> HOUR, set hour 5, then simultaneous sel+inc
        sel_pulse(1);
        inc_pulse(5);
        chk("hour_5", 32'(edit_hour), 5);
        sel_key = 1'b1;
        inc_key = 1'b1;
        cyc(1);
        sel_key = 1'b0;
        inc_key = 1'b0;
        cyc(1);
        chk_time("sel_inc_same", 5, 8, 0);
        inc_pulse(1);
        chk_time("now_in_min", 5, 9, 0);
        inc_pulse(1);
        chk("min_10", 32'(edit_min), 10);
        chk("pre_exit_load", 32'(load_time), 0);

        // Exit coinciding with an inc edge
        set_time_en = 1'b0;
        inc_key = 1'b1;
        cyc(1);
        chk("exit_load", 32'(load_time), 1);
        chk("exit_min", 32'(edit_min), 10);
        inc_key = 1'b0;
        cyc(1);
        chk("exit_load_off", 32'(load_time), 0);
        chk_time("exit_hold", 5, 10, 0);
        chk("idle_mask", 32'(blink_mask), 0);
        inc_pulse(1);
        ticks(25);
        chk("idle_inc_ignored", 32'(edit_min), 10);
        chk("idle_mask_ticks", 32'(blink_mask), 0);

        // Reset mid-edit in SEC
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        set_time_en = 1'b1;
        cyc(1);
        chk_time("resnap", 1, 2, 3);
        sel_pulse(2);
        inc_pulse(1);
        chk("pre_reset_sec", 32'(edit_sec), 4);
        rst_n = 1'b0;
        set_time_en = 1'b0;
        cyc(2);
        chk_time("mid_reset", 0, 0, 0);
        chk("mid_reset_load", 32'(load_time), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("post_reset_load", 32'(load_time), 0);
        cyc(1);
        chk("post_reset_load2", 32'(load_time), 0);
        chk("post_reset_mask", 32'(blink_mask), 0);
        cur_hour = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
        set_time_en = 1'b1;
        cyc(1);
        chk_time("post_reset_snap", 7, 8, 9);

        // Out-of-range snapshot wraps to 0 on next increment
        set_time_en = 1'b0;
        cyc(1);
        chk("oor_exit_load", 32'(load_time), 1);
        cur_hour = 5'd30; cur_min = 6'd63; cur_sec = 6'd60;
        set_time_en = 1'b1;
        cyc(1);
        chk("oor_load_off", 32'(load_time), 0);
        chk_time("oor_snap", 30, 63, 60);
        inc_pulse(1);
        sel_pulse(1);
        inc_pulse(1);
        chk_time("oor_wrap", 0, 0, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_set_sequencer.md
# time_set_sequencer

Field-level editing controller for the clock's time-setting mode. While the mode state machine holds `set_time_en` high, this block snapshots the running time and steps the user through the hour, minute and second fields. It increments the selected field on key presses, with auto-repeat on long press, and drives a blink mask for the display. When `set_time_en` falls, it commits the edited time to the time counter with a one-cycle load strobe.

## Interface
- `HOLD_TICKS`, 50: `tick` pulses an inc key must be held before the first auto-repeat.
- `REPEAT_TICKS`, 10: `tick` pulses between subsequent auto-repeat increments.
- `BLINK_TICKS`, 25: `tick` pulses per blink half-period.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `tick` in 1: single-cycle timebase pulse (10 ms nominal).
- `set_time_en` in 1: level from the mode state machine; high = time-setting mode.
- `sel_key` in 1: debounced, synchronized field-select key, active high.
- `inc_key` in 1: debounced, synchronized increment key, active high.
- `cur_hour` in 5: running hour, 0..23.
- `cur_min` in 6: running minute, 0..59.
- `cur_sec` in 6: running second, 0..59.
- `edit_hour` out 5: edited hour.
- `edit_min` out 6: edited minute.
- `edit_sec` out 6: edited second.
- `load_time` out 1: one-cycle commit strobe to the time counter.
- `blink_mask` out 3: {hour, min, sec}; 1 = blank this field on the display now.

## Operation
- States: IDLE, HOUR, MIN, SEC. Reset enters IDLE.
- **Entry:** the rising edge of `set_time_en` (en=1, en_d=0) copies `cur_*` into `edit_*` and moves to HOUR.
- **Field select:** a `sel_key` rising edge steps HOUR→MIN→SEC→HOUR.
- **Increment:** an `inc_key` rising edge increments the selected field.
  - Hour wraps 23→0.
  - Minute and second wrap 59→0.
  - Other fields are untouched; there is no carry between fields.
- **Auto-repeat:**
  - While `inc_key` stays high, a hold counter counts `tick` pulses from the press.
  - At HOLD_TICKS it issues one increment and reloads with REPEAT_TICKS.
  - It then issues one increment every REPEAT_TICKS ticks.
  - Releasing the key clears the counter.
- **Field change while held:** a select edge while `inc_key` is held clears the hold counter. Repeat restarts only after a new press.
- **Blink:**
  - A phase bit toggles every BLINK_TICKS ticks.
  - `blink_mask` is the one-hot of the selected field gated by the phase bit.
  - Each increment or field change forces the phase to visible (mask 000) and restarts the blink count.
  - In IDLE, `blink_mask` = 000.
- **Exit:** the falling edge of `set_time_en` in HOUR/MIN/SEC pulses `load_time` for one cycle with `edit_*` stable and returns to IDLE. `edit_*` hold their values in IDLE.
- **Simultaneous events:**
  - Select and inc edges in the same cycle: select wins, the inc edge is discarded.
  - Exit in the same cycle as a key edge: exit wins, the key is discarded and the committed value excludes it.
  - An increment from `tick` coinciding with an exit is discarded.
- **Out-of-range snapshot:** if `cur_*` is out of range at entry, it is still captured. The next increment of that field wraps it to 0.
- **Reset mid-edit:** the block returns to IDLE with all outputs cleared, and no `load_time` pulse is produced.

## Timing
- All outputs are registered.
- Reset values: `edit_hour`=0, `edit_min`=0, `edit_sec`=0, `load_time`=0, `blink_mask`=000.
- Key and enable edges are detected against a one-cycle delayed copy. The action commits on the clock edge that samples the edge, so the new value is visible the following cycle.
- `load_time` is high for exactly the one cycle after the edge that samples `set_time_en`=0 with en_d=1.
- Auto-repeat increments land on the edge that samples the qualifying `tick`.

## Configuration
- `TIME_SET_DEC_KEY_EN`:
  - **Defined:** adds input `dec_key` (1 bit). It decrements the selected field with wrap (hour 0→23, min/sec 0→59) and uses the same auto-repeat and blink-restart rules as `inc_key`. The two keys share one hold counter. Simultaneous inc and dec rising edges are both discarded. While both keys are held, repeat is suppressed.
  - **Undefined:** the `dec_key` port and all decrement logic are absent.

## Test plan
- Reset, then `cur_*`=12:34:56 and `set_time_en` 0→1: `edit_*`=12:34:56 one cycle later, state HOUR, `blink_mask`=000 until BLINK_TICKS ticks, then 100.
- In HOUR with `edit_hour`=23, pulse `inc_key` → `edit_hour`=0 and `edit_min`/`edit_sec` unchanged. Select twice, set `edit_sec`=59, pulse inc → `edit_sec`=0, `edit_min` unchanged.
- Hold `inc_key` 100 ticks in MIN starting from 0, defaults: exactly 1 (edge) + 1 (tick 50) + 5 (ticks 60..100) = 7 increments → `edit_min`=7.
- Same-cycle `sel_key` and `inc_key` rising in HOUR=5 → state MIN, `edit_hour`=5.
- Drop `set_time_en` in the same cycle as an `inc_key` edge with `edit_min`=10: `load_time` is a single 1-cycle pulse with `edit_min`=10, then state IDLE and `blink_mask`=000.
- Assert `rst_n`=0 mid-edit (in SEC) then release: outputs are all zero, no `load_time`, and the next `set_time_en` rise re-snapshots `cur_*`.
